mem_arbiter: RTL and testbench

- Shares one single-port unified RAM between instruction fetch (IF, read-only) and data memory access (DM, read/write with 4-bit byte enables).
- The RAM has a fixed read latency.
- The block sequences each access: grant, memory strobe, latency count, response pulse.
- The requester is expected to stall (hold its request) until granted.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF/DM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_w_en;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;

    logic              mem_cs;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_w_en;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_w_en, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_cs, mem_addr, mem_w_en, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_w_en, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_cs, mem_addr, mem_w_en, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port RAM between IF and DM. DM beats IF on conflicts, or they alternate with ARB_RR_EN.
// Latency: the grant and the RAM strobe occur in the same cycle. The response pulse arrives MEM_LAT cycles later.
// Backpressure: a request waits without a grant while an access is in flight; the next grant can overlap the response.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_t           owner_q, owner_d;
    logic             wr_q, wr_d;
`ifdef ARB_RR_EN
    owner_t           last_q, last_d;
`endif

    logic resp;
    logic grant;
    logic dm_win;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
            wr_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        wr_d    = wr_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
        dm_win  = bus.dm_req && (!bus.if_req || (last_q == OWN_IF));
`else
        dm_win  = bus.dm_req;
`endif
        resp  = (state_q == BUSY) && (cnt_q == CNT_ONE);
        // Gating the grant with rst_n keeps every output low while reset is asserted.
        grant = rst_n && ((state_q == IDLE) || resp) && (bus.if_req || bus.dm_req);

        if (grant) begin
            state_d = BUSY;
            cnt_d   = CNT_LAT;
            owner_d = dm_win ? OWN_DM : OWN_IF;
            wr_d    = dm_win && (bus.dm_w_en != 4'b0000);
`ifdef ARB_RR_EN
            last_d  = owner_d;
`endif
        end else if (resp) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - CNT_ONE;
        end
    end

    assign bus.if_gnt    = grant && !dm_win;
    assign bus.dm_gnt    = grant && dm_win;
    assign bus.mem_cs    = grant;
    assign bus.mem_addr  = !grant ? '0 :
                           dm_win ? bus.dm_addr[ADDR_W-1:2] : bus.if_addr[ADDR_W-1:2];
    assign bus.mem_w_en  = (grant && dm_win) ? bus.dm_w_en  : 4'b0000;
    assign bus.mem_wdata = (grant && dm_win) ? bus.dm_wdata : 32'h0;

    // The RAM output is only meaningful in the response cycle of the current owner.
    assign bus.if_rvalid = resp && (owner_q == OWN_IF);
    assign bus.dm_rvalid = resp && (owner_q == OWN_DM);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.dm_rdata  = (bus.dm_rvalid && !wr_q) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter. A queue-based scoreboard is fed by a reference model of the arbitration rules.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LAT    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus  ();
    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(1))   u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h1234_0000;
    endfunction

    // Environment RAM with fixed read latency LAT. Junk is shifted in when the RAM is not strobed.
    logic [31:0] ram [bit [29:0]];
    logic [31:0] pipe [LAT];
    assign bus.mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        logic [31:0] cur;
        if (bus.mem_cs) begin
            cur = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : init_word(bus.mem_addr);
            pipe[0] <= cur;
            for (int b = 0; b < 4; b++)
                if (bus.mem_w_en[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            ram[bus.mem_addr] = cur;
        end else begin
            pipe[0] <= $urandom;
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // RAM for the MEM_LAT=1 instance: the returned word is a pure function of the address.
    always @(posedge clk)
        bus1.mem_rdata <= bus1.mem_cs ? {~bus1.mem_addr[15:0], bus1.mem_addr[15:0]} : $urandom;

    // Reference model state
    logic [31:0] ref_mem [bit [29:0]];
    typedef struct { int due; logic [31:0] data; } exp_t;
    exp_t if_q[$];
    exp_t dm_q[$];
    int   free_at = 0;
    logic last_dm = 1'b0;

    // Requester intent, applied to the bus at each negedge
    logic        ir = 1'b0, dr = 1'b0;
    logic [31:0] ia = '0, da = '0, dd = '0;
    logic [3:0]  dw = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic model_check();
        logic        can, dmw;
        logic [29:0] w;
        logic [31:0] cur;
        exp_t        e;
        can = (cyc >= free_at) && (ir || dr);
`ifdef ARB_RR_EN
        dmw = dr && (!ir || !last_dm);
`else
        dmw = dr;
`endif
        chk("if_gnt", bus.if_gnt, can && !dmw);
        chk("dm_gnt", bus.dm_gnt, can && dmw);
        chk("mem_cs", bus.mem_cs, can);
        if (can) begin
            w = dmw ? da[31:2] : ia[31:2];
            chk("mem_addr",  bus.mem_addr,  w);
            chk("mem_w_en",  bus.mem_w_en,  dmw ? dw : 4'b0000);
            chk("mem_wdata", bus.mem_wdata, dmw ? dd : 32'h0);
            e.due = cyc + LAT;
            if (dmw) begin
                if (dw == 4'b0000) begin
                    e.data = ref_rd(w);
                end else begin
                    cur = ref_rd(w);
                    for (int b = 0; b < 4; b++)
                        if (dw[b]) cur[8*b +: 8] = dd[8*b +: 8];
                    ref_mem[w] = cur;
                    e.data = 32'h0;
                end
                dm_q.push_back(e);
                dr = 1'b0;
            end else begin
                e.data = ref_rd(w);
                if_q.push_back(e);
                ir = 1'b0;
            end
            free_at = cyc + LAT;
            last_dm = dmw;
        end else begin
            chk("mem_idle", {bus.mem_addr, bus.mem_w_en, bus.mem_wdata}, 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_req   = dr;
        bus.dm_addr  = da;
        bus.dm_w_en  = dw;
        bus.dm_wdata = dd;
        #1;
        model_check();
    endtask

    task automatic outputs_zero(input string name);
        chk(name, {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_cs,
                   bus.mem_w_en, bus.mem_addr != 0, bus.mem_wdata != 0,
                   bus.if_rdata != 0, bus.dm_rdata != 0}, 0);
    endtask

    // Monitor: pops the expected responses as the DUT presents them.
    task automatic mon_side(input string nm, input logic vld, input logic [31:0] rd, inout exp_t q[$]);
        exp_t e;
        if (vld) begin
            if (q.size() == 0) begin
                chk({nm, "_rvalid_unexpected"}, 1, 0);
            end else begin
                e = q.pop_front();
                chk({nm, "_resp_cycle"}, cyc, e.due);
                chk({nm, "_rdata"}, rd, e.data);
            end
        end else begin
            chk({nm, "_rdata_idle"}, rd, 0);
            if (q.size() != 0 && q[0].due <= cyc) begin
                chk({nm, "_rvalid_missing"}, 0, 1);
                void'(q.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            mon_side("if", bus.if_rvalid, bus.if_rdata, if_q);
            mon_side("dm", bus.dm_rvalid, bus.dm_rdata, dm_q);
        end
    end

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [15:0] w16;
        bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.if_addr = 32'h10; bus.dm_addr = 32'h20;
        bus.dm_w_en = 4'hF; bus.dm_wdata = 32'h55; 
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_addr = '0;
        bus1.dm_w_en = '0; bus1.dm_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            outputs_zero("reset_outputs");
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        rst_n = 1'b1;

        // IF read of a preloaded word
        ram[30'h41] = 32'hDEAD_BEEF; ref_mem[30'h41] = 32'hDEAD_BEEF;
        ir = 1'b1; ia = 32'h0000_0104;
        drain(6);

        // DM single-byte write, then read it back
        dr = 1'b1; da = 32'h203; dw = 4'b1000; dd = 32'hAA00_0000;
        drain(4);
        dr = 1'b1; da = 32'h200; dw = 4'b0000;
        drain(4);

        // Simultaneous requests, both held until granted
        ir = 1'b1; ia = 32'h40; dr = 1'b1; da = 32'h84; dw = 4'b0000;
        drain(8);

        // Continuous contention over several grants
        for (int i = 0; i < 4 * LAT; i++) begin
            if (!ir) begin ir = 1'b1; ia = ia + 4; end
            if (!dr) begin dr = 1'b1; da = da + 4; end
            tick();
        end
        ir = 1'b0; dr = 1'b0;
        drain(6);

        // Reset while an IF read is in flight
        ir = 1'b1; ia = 32'h100;
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        if_q.delete(); dm_q.delete();
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        #1;
        outputs_zero("reset_mid_access");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            outputs_zero("reset_hold");
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        rst_n = 1'b1;
        free_at = 0; last_dm = 1'b0;
        ir = 1'b1; ia = 32'h100; dr = 1'b0;
        drain(6);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if (!ir && $urandom_range(0, 1) == 1) begin
                ir = 1'b1; ia = 32'($urandom_range(0, 1023));
            end else if (ir && $urandom_range(0, 15) == 0) begin
                ir = 1'b0;
            end
            if (!dr && $urandom_range(0, 1) == 1) begin
                dr = 1'b1; da = 32'($urandom_range(0, 1023)); dd = $urandom;
                dw = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            end else if (dr && $urandom_range(0, 15) == 0) begin
                dr = 1'b0;
            end
            tick();
        end
        ir = 1'b0; dr = 1'b0;
        drain(2 * LAT + 2);
        chk("if_queue_empty", if_q.size(), 0);
        chk("dm_queue_empty", dm_q.size(), 0);

        // Back-to-back IF reads on the single-cycle-latency instance
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus1.if_req  = (k < 4);
            bus1.if_addr = 32'h400 + 32'(4 * k);
            #1;
            chk("b2b_if_gnt", bus1.if_gnt, k < 4);
            chk("b2b_mem_cs", bus1.mem_cs, k < 4);
            if (k < 4) chk("b2b_mem_addr", bus1.mem_addr, 30'h100 + 30'(k));
            if (k >= 1 && k <= 4) begin
                w16 = 16'h100 + 16'(k - 1);
                chk("b2b_if_rvalid", bus1.if_rvalid, 1);
                chk("b2b_if_rdata", bus1.if_rdata, {~w16, w16});
            end else begin
                chk("b2b_if_rvalid", bus1.if_rvalid, 0);
            end
        end
        @(negedge clk);
        bus1.if_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
